// File: rtl/riscv_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : riscv_multicycle_ctrl
// Brief    : Main control FSM of the multicycle RV32I core (fetch/decode/
//            execute/writeback sequencing, memory stall, illegal-op trap).
// Revision : 1.0 - initial release
// ============================================================================

// Immediate format codes shared with the immediate extender.
`ifndef I_TYPE
`define I_TYPE 2'b00
`endif
`ifndef S_TYPE
`define S_TYPE 2'b01
`endif
`ifndef B_TYPE
`define B_TYPE 2'b10
`endif

module riscv_multicycle_ctrl #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7_5,
    input  logic       i_zero,
    input  logic       i_mem_ready,
    output logic       o_pc_write,
    output logic       o_ir_write,
    output logic       o_adr_src,
    output logic       o_mem_write,
    output logic       o_reg_write,
    output logic [1:0] o_result_src,
    output logic [1:0] o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic [2:0] o_alu_ctrl,
    output logic [1:0] o_imm_ext_src,
    output logic       o_illegal
);

    localparam logic [3:0] c_S_FETCH    = 4'd0;
    localparam logic [3:0] c_S_DECODE   = 4'd1;
    localparam logic [3:0] c_S_MEMADR   = 4'd2;
    localparam logic [3:0] c_S_MEMREAD  = 4'd3;
    localparam logic [3:0] c_S_MEMWB    = 4'd4;
    localparam logic [3:0] c_S_MEMWRITE = 4'd5;
    localparam logic [3:0] c_S_EXER     = 4'd6;
    localparam logic [3:0] c_S_EXEI     = 4'd7;
    localparam logic [3:0] c_S_ALUWB    = 4'd8;
    localparam logic [3:0] c_S_BRANCH   = 4'd9;
    localparam logic [3:0] c_S_TRAP     = 4'd10;

    localparam logic [2:0] c_ALU_ADD = 3'b000;
    localparam logic [2:0] c_ALU_SUB = 3'b001;
    localparam logic [2:0] c_ALU_AND = 3'b010;
    localparam logic [2:0] c_ALU_OR  = 3'b011;
    localparam logic [2:0] c_ALU_XOR = 3'b100;
    localparam logic [2:0] c_ALU_SLT = 3'b101;
    localparam logic [2:0] c_ALU_SLL = 3'b110;
    localparam logic [2:0] c_ALU_SRL = 3'b111;

    localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
    localparam logic [6:0] c_OP_STORE = 7'b0100011;
    localparam logic [6:0] c_OP_R     = 7'b0110011;
    localparam logic [6:0] c_OP_I     = 7'b0010011;
    localparam logic [6:0] c_OP_BR    = 7'b1100011;

    logic [3:0] r_state;
    logic [3:0] w_next_state;
    logic       w_is_r;
    logic       w_alu_illegal;
    logic [2:0] w_alu_dec;
    logic       w_pc_write;
    logic       w_ir_write;
    logic       w_adr_src;
    logic       w_mem_write;
    logic       w_reg_write;
    logic [1:0] w_result_src;
    logic [1:0] w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [2:0] w_alu_ctrl;
    logic [1:0] w_imm_ext_src;
    logic       w_illegal;

    assign w_is_r = (i_opcode == c_OP_R);

    // SLTU/SLTIU, arithmetic shifts and any other bit-30 R-type form are unsupported.
    assign w_alu_illegal = (i_funct3 == 3'b011)
                         | (i_funct7_5 & ((i_funct3 == 3'b101) | (i_funct3 == 3'b001)))
                         | (w_is_r & i_funct7_5 & (i_funct3 != 3'b000));

    always_comb begin
        w_alu_dec = c_ALU_ADD;
        case (i_funct3)
            3'b000:  w_alu_dec = (w_is_r && i_funct7_5) ? c_ALU_SUB : c_ALU_ADD;
            3'b001:  w_alu_dec = c_ALU_SLL;
            3'b010:  w_alu_dec = c_ALU_SLT;
            3'b100:  w_alu_dec = c_ALU_XOR;
            3'b101:  w_alu_dec = c_ALU_SRL;
            3'b110:  w_alu_dec = c_ALU_OR;
            3'b111:  w_alu_dec = c_ALU_AND;
            default: w_alu_dec = c_ALU_ADD;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= RESET_STATE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state  = r_state;
        w_pc_write    = 1'b0;
        w_ir_write    = 1'b0;
        w_adr_src     = 1'b0;
        w_mem_write   = 1'b0;
        w_reg_write   = 1'b0;
        w_result_src  = 2'b00;
        w_alu_src_a   = 2'b00;
        w_alu_src_b   = 2'b00;
        w_alu_ctrl    = c_ALU_ADD;
        w_imm_ext_src = `I_TYPE;
        w_illegal     = 1'b0;
        case (r_state)
            c_S_FETCH: begin
                w_alu_src_b  = 2'b10;
                w_result_src = 2'b10;
                w_pc_write   = i_mem_ready;
                w_ir_write   = i_mem_ready;
                if (i_mem_ready) w_next_state = c_S_DECODE;
            end
            c_S_DECODE: begin
                // Branch target is computed here so BRANCH can reuse the ALU for the compare.
                w_alu_src_a   = 2'b01;
                w_alu_src_b   = 2'b01;
                w_imm_ext_src = `B_TYPE;
                case (i_opcode)
                    c_OP_LOAD, c_OP_STORE:
                        w_next_state = (i_funct3 == 3'b010) ? c_S_MEMADR : c_S_TRAP;
                    c_OP_R, c_OP_I:
                        w_next_state = w_alu_illegal ? c_S_TRAP : (w_is_r ? c_S_EXER : c_S_EXEI);
                    c_OP_BR:
                        w_next_state = (i_funct3[2:1] == 2'b00) ? c_S_BRANCH : c_S_TRAP;
                    default:
                        w_next_state = c_S_TRAP;
                endcase
            end
            c_S_MEMADR: begin
                w_alu_src_a   = 2'b10;
                w_alu_src_b   = 2'b01;
                w_imm_ext_src = (i_opcode == c_OP_LOAD) ? `I_TYPE : `S_TYPE;
                w_next_state  = (i_opcode == c_OP_LOAD) ? c_S_MEMREAD : c_S_MEMWRITE;
            end
            c_S_MEMREAD: begin
                w_adr_src = 1'b1;
                if (i_mem_ready) w_next_state = c_S_MEMWB;
            end
            c_S_MEMWB: begin
                w_result_src = 2'b01;
                w_reg_write  = 1'b1;
                w_next_state = c_S_FETCH;
            end
            c_S_MEMWRITE: begin
                w_adr_src   = 1'b1;
                w_mem_write = 1'b1;
                if (i_mem_ready) w_next_state = c_S_FETCH;
            end
            c_S_EXER: begin
                w_alu_src_a  = 2'b10;
                w_alu_ctrl   = w_alu_dec;
                w_next_state = c_S_ALUWB;
            end
            c_S_EXEI: begin
                w_alu_src_a  = 2'b10;
                w_alu_src_b  = 2'b01;
                w_alu_ctrl   = w_alu_dec;
                w_next_state = c_S_ALUWB;
            end
            c_S_ALUWB: begin
                w_reg_write  = 1'b1;
                w_next_state = c_S_FETCH;
            end
            c_S_BRANCH: begin
                w_alu_src_a  = 2'b10;
                w_alu_ctrl   = c_ALU_SUB;
                w_pc_write   = i_funct3[0] ? ~i_zero : i_zero;
                w_next_state = c_S_FETCH;
            end
            c_S_TRAP: begin
                w_illegal = 1'b1;
            end
            default: begin
                w_next_state = c_S_TRAP;
            end
        endcase
    end

    // Reset gates the enables combinationally so nothing strobes while it is high.
    assign o_pc_write    = w_pc_write  & ~i_rst;
    assign o_ir_write    = w_ir_write  & ~i_rst;
    assign o_mem_write   = w_mem_write & ~i_rst;
    assign o_reg_write   = w_reg_write & ~i_rst;
    assign o_illegal     = w_illegal   & ~i_rst;
    assign o_adr_src     = w_adr_src;
    assign o_result_src  = w_result_src;
    assign o_alu_src_a   = w_alu_src_a;
    assign o_alu_src_b   = w_alu_src_b;
    assign o_alu_ctrl    = w_alu_ctrl;
    assign o_imm_ext_src = w_imm_ext_src;

`ifdef DEBUG
    logic [63:0] w_state_name;
    always_comb begin
        w_state_name = "UNKNOWN ";
        case (r_state)
            c_S_FETCH:    w_state_name = "FETCH   ";
            c_S_DECODE:   w_state_name = "DECODE  ";
            c_S_MEMADR:   w_state_name = "MEMADR  ";
            c_S_MEMREAD:  w_state_name = "MEMREAD ";
            c_S_MEMWB:    w_state_name = "MEMWB   ";
            c_S_MEMWRITE: w_state_name = "MEMWRITE";
            c_S_EXER:     w_state_name = "EXER    ";
            c_S_EXEI:     w_state_name = "EXEI    ";
            c_S_ALUWB:    w_state_name = "ALUWB   ";
            c_S_BRANCH:   w_state_name = "BRANCH  ";
            c_S_TRAP:     w_state_name = "TRAP    ";
            default:      w_state_name = "UNKNOWN ";
        endcase
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_riscv_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_multicycle_ctrl
// Brief    : Table-driven bench for riscv_multicycle_ctrl plus stall/trap/reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_multicycle_ctrl;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic [6:0] i_opcode;
    logic [2:0] i_funct3;
    logic       i_funct7_5;
    logic       i_zero;
    logic       i_mem_ready;
    logic       o_pc_write, o_ir_write, o_adr_src, o_mem_write, o_reg_write, o_illegal;
    logic [1:0] o_result_src, o_alu_src_a, o_alu_src_b, o_imm_ext_src;
    logic [2:0] o_alu_ctrl;

    riscv_multicycle_ctrl #(.RESET_STATE(4'd0)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_opcode(i_opcode), .i_funct3(i_funct3),
        .i_funct7_5(i_funct7_5), .i_zero(i_zero), .i_mem_ready(i_mem_ready),
        .o_pc_write(o_pc_write), .o_ir_write(o_ir_write), .o_adr_src(o_adr_src),
        .o_mem_write(o_mem_write), .o_reg_write(o_reg_write), .o_result_src(o_result_src),
        .o_alu_src_a(o_alu_src_a), .o_alu_src_b(o_alu_src_b), .o_alu_ctrl(o_alu_ctrl),
        .o_imm_ext_src(o_imm_ext_src), .o_illegal(o_illegal)
    );

    always #5 i_clk = ~i_clk;

    // {pc, ir, adr, mw, rw, result[2], a[2], b[2], alu[3], imm[2], illegal}
    logic [16:0] act;
    assign act = {o_pc_write, o_ir_write, o_adr_src, o_mem_write, o_reg_write, o_result_src,
                  o_alu_src_a, o_alu_src_b, o_alu_ctrl, o_imm_ext_src, o_illegal};

    function automatic logic [16:0] sig(input logic pc, input logic ir, input logic adr,
                                        input logic mw, input logic rw, input logic [1:0] res,
                                        input logic [1:0] a, input logic [1:0] b,
                                        input logic [2:0] alu, input logic [1:0] imm,
                                        input logic ill);
        return {pc, ir, adr, mw, rw, res, a, b, alu, imm, ill};
    endfunction

    typedef struct {
        logic [63:0]      name;
        logic [6:0]       op;
        logic [2:0]       f3;
        logic             f7;
        logic             zero;
        int               n;
        logic             trap;
        logic [4:0][16:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [16:0] e_fetch, e_fstall, e_dec, e_aluwb, e_madr_l, e_madr_s;
    logic [16:0] e_mread, e_mwb, e_mwr, e_trap;

    function automatic logic [16:0] e_exer(input logic [2:0] alu);
        return sig(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, alu, 2'b00, 0);
    endfunction
    function automatic logic [16:0] e_exei(input logic [2:0] alu);
        return sig(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, alu, 2'b00, 0);
    endfunction
    function automatic logic [16:0] e_br(input logic pc);
        return sig(pc, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b00, 0);
    endfunction

    task automatic add_vec(input logic [63:0] name, input logic [6:0] op, input logic [2:0] f3,
                           input logic f7, input logic zero, input int n, input logic trap,
                           input logic [16:0] e2, input logic [16:0] e3, input logic [16:0] e4);
        vec_t v;
        v.name = name; v.op = op; v.f3 = f3; v.f7 = f7; v.zero = zero; v.n = n; v.trap = trap;
        v.exp[0] = e_fetch; v.exp[1] = e_dec; v.exp[2] = e2; v.exp[3] = e3; v.exp[4] = e4;
        vecs.push_back(v);
    endtask

    task automatic check(input logic [63:0] name, input int cyc, input logic [16:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic step(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                        input logic zero, input logic ready);
        @(negedge i_clk);
        i_opcode = op; i_funct3 = f3; i_funct7_5 = f7; i_zero = zero; i_mem_ready = ready;
        #1;
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_rst = 1'b1;
        i_mem_ready = 1'b1;
        #1;
        check("rst_hold", 0, e_fstall);
        @(negedge i_clk);
        i_mem_ready = 1'b0;
        i_rst = 1'b0;
    endtask

    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_L = 7'b0000011;
    localparam logic [6:0] OP_S = 7'b0100011, OP_B = 7'b1100011, OP_JAL = 7'b1101111;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        e_fetch  = sig(1, 1, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0);
        e_fstall = sig(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0);
        e_dec    = sig(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b10, 0);
        e_aluwb  = sig(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0);
        e_madr_l = sig(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 0);
        e_madr_s = sig(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b01, 0);
        e_mread  = sig(0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0);
        e_mwb    = sig(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 2'b00, 0);
        e_mwr    = sig(0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0);
        e_trap   = sig(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1);

        add_vec("add     ", OP_R, 3'b000, 0, 0, 4, 0, e_exer(3'b000), e_aluwb, '0);
        add_vec("sub     ", OP_R, 3'b000, 1, 0, 4, 0, e_exer(3'b001), e_aluwb, '0);
        add_vec("and     ", OP_R, 3'b111, 0, 0, 4, 0, e_exer(3'b010), e_aluwb, '0);
        add_vec("or      ", OP_R, 3'b110, 0, 0, 4, 0, e_exer(3'b011), e_aluwb, '0);
        add_vec("xor     ", OP_R, 3'b100, 0, 0, 4, 0, e_exer(3'b100), e_aluwb, '0);
        add_vec("slt     ", OP_R, 3'b010, 0, 0, 4, 0, e_exer(3'b101), e_aluwb, '0);
        add_vec("sll     ", OP_R, 3'b001, 0, 0, 4, 0, e_exer(3'b110), e_aluwb, '0);
        add_vec("srl     ", OP_R, 3'b101, 0, 0, 4, 0, e_exer(3'b111), e_aluwb, '0);
        add_vec("addi_b30", OP_I, 3'b000, 1, 0, 4, 0, e_exei(3'b000), e_aluwb, '0);
        add_vec("xori    ", OP_I, 3'b100, 0, 0, 4, 0, e_exei(3'b100), e_aluwb, '0);
        add_vec("slli    ", OP_I, 3'b001, 0, 0, 4, 0, e_exei(3'b110), e_aluwb, '0);
        add_vec("beq_z1  ", OP_B, 3'b000, 0, 1, 3, 0, e_br(1), '0, '0);
        add_vec("beq_z0  ", OP_B, 3'b000, 0, 0, 3, 0, e_br(0), '0, '0);
        add_vec("bne_z0  ", OP_B, 3'b001, 0, 0, 3, 0, e_br(1), '0, '0);
        add_vec("bne_z1  ", OP_B, 3'b001, 0, 1, 3, 0, e_br(0), '0, '0);
        add_vec("lw      ", OP_L, 3'b010, 0, 0, 5, 0, e_madr_l, e_mread, e_mwb);
        add_vec("sw      ", OP_S, 3'b010, 0, 0, 4, 0, e_madr_s, e_mwr, '0);
        add_vec("sltu    ", OP_R, 3'b011, 0, 0, 3, 1, e_trap, '0, '0);
        add_vec("sltiu   ", OP_I, 3'b011, 0, 0, 3, 1, e_trap, '0, '0);
        add_vec("sra     ", OP_R, 3'b101, 1, 0, 3, 1, e_trap, '0, '0);
        add_vec("r_b30and", OP_R, 3'b111, 1, 0, 3, 1, e_trap, '0, '0);
        add_vec("slli_b30", OP_I, 3'b001, 1, 0, 3, 1, e_trap, '0, '0);
        add_vec("jal     ", OP_JAL, 3'b000, 0, 0, 3, 1, e_trap, '0, '0);
        add_vec("lb      ", OP_L, 3'b000, 0, 0, 3, 1, e_trap, '0, '0);
        add_vec("blt     ", OP_B, 3'b100, 0, 0, 3, 1, e_trap, '0, '0);

        i_rst = 1'b1; i_opcode = '0; i_funct3 = '0; i_funct7_5 = 0; i_zero = 0; i_mem_ready = 1'b1;
        #1;
        check("reset   ", 0, e_fstall);
        @(negedge i_clk);
        i_mem_ready = 1'b0;
        i_rst = 1'b0;

        foreach (vecs[i]) begin
            for (int c = 0; c < vecs[i].n; c++) begin
                step(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].zero, 1'b1);
                check(vecs[i].name, c, vecs[i].exp[c]);
            end
            if (vecs[i].trap) do_reset();
        end

        // lw with fetch stall and two wait cycles in MEMREAD
        step(OP_L, 3'b010, 0, 0, 0); check("lw_fstl ", 0, e_fstall);
        step(OP_L, 3'b010, 0, 0, 1); check("lw_fetch", 1, e_fetch);
        step(OP_L, 3'b010, 0, 0, 1); check("lw_dec  ", 2, e_dec);
        step(OP_L, 3'b010, 0, 0, 1); check("lw_madr ", 3, e_madr_l);
        step(OP_L, 3'b010, 0, 0, 0); check("lw_rd0  ", 4, e_mread);
        step(OP_L, 3'b010, 0, 0, 0); check("lw_rd1  ", 5, e_mread);
        step(OP_L, 3'b010, 0, 0, 1); check("lw_rd2  ", 6, e_mread);
        step(OP_L, 3'b010, 0, 0, 1); check("lw_wb   ", 7, e_mwb);

        // sw holding mem_write across two wait cycles
        step(OP_S, 3'b010, 0, 0, 1); check("sw_fetch", 0, e_fetch);
        step(OP_S, 3'b010, 0, 0, 1); check("sw_dec  ", 1, e_dec);
        step(OP_S, 3'b010, 0, 0, 1); check("sw_madr ", 2, e_madr_s);
        step(OP_S, 3'b010, 0, 0, 0); check("sw_wr0  ", 3, e_mwr);
        step(OP_S, 3'b010, 0, 0, 0); check("sw_wr1  ", 4, e_mwr);
        step(OP_S, 3'b010, 0, 0, 1); check("sw_wr2  ", 5, e_mwr);
        step(OP_S, 3'b010, 0, 0, 0); check("sw_done ", 6, e_fstall);

        // srai traps and stays trapped until reset
        step(OP_I, 3'b101, 1, 0, 1); check("srai_f  ", 0, e_fetch);
        step(OP_I, 3'b101, 1, 0, 1); check("srai_d  ", 1, e_dec);
        for (int k = 0; k < 10; k++) begin
            step(OP_I, 3'b101, 1, k[0], 1);
            check("trap_hld", k, e_trap);
        end
        do_reset();
        step(OP_I, 3'b101, 1, 0, 0); check("trap_clr", 0, e_fstall);

        // asynchronous reset in the middle of a stalled store
        step(OP_S, 3'b010, 0, 0, 1); check("rsw_f   ", 0, e_fetch);
        step(OP_S, 3'b010, 0, 0, 1); check("rsw_d   ", 1, e_dec);
        step(OP_S, 3'b010, 0, 0, 1); check("rsw_madr", 2, e_madr_s);
        step(OP_S, 3'b010, 0, 0, 0); check("rsw_wr  ", 3, e_mwr);
        #2 i_rst = 1'b1;
        #1 check("rsw_async", 4, e_fstall);
        @(negedge i_clk);
        i_rst = 1'b0;
        step(OP_S, 3'b010, 0, 0, 0); check("rsw_post", 5, e_fstall);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
